alu_cmd_issuer: RTL and testbench

//  Sequential front-end driving the 2-bit combinational ALU: accepts packed ALU commands over a

---
 rtl/alu_cmd_issuer.sv | 179 +++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Command FIFO + sequencer in front of the 2-bit combinational ALU: queues packed commands,
// drives ALU operands, captures the settled result and returns it with an acceptance-order tag.
// Optional build macro ALU_SELFCHECK_EN adds a golden model and a sticky err output.
module alu_cmd_issuer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_data,
    output logic [1:0]       alu_a,
    output logic [1:0]       alu_b,
    output logic             alu_cin,
    output logic [2:0]       alu_control,
    input  logic [3:0]       alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
`ifdef ALU_SELFCHECK_EN
    output logic             err,
`endif
    output logic             busy
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int ENTRY_W = TAG_W + 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [PTR_W:0]   FIFO_CAP = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_reg, rd_ptr_reg;
    logic [TAG_W-1:0]   accept_tag_reg;
    logic [TAG_W-1:0]   pend_tag_reg;
    logic [CNT_W-1:0]   settle_cnt_reg;
    logic [ENTRY_W-1:0] head_entry;
    logic               fifo_empty, fifo_full;
    logic               push, pop, capture, rsp_done;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = ((wr_ptr_reg - rd_ptr_reg) == FIFO_CAP);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign head_entry = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
    assign busy       = (state_reg != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {accept_tag_reg, cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            accept_tag_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg     <= wr_ptr_reg + 1'b1;
                accept_tag_reg <= accept_tag_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_cnt_reg == CNT_LAST) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand, settle-counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a          <= '0;
            alu_b          <= '0;
            alu_cin        <= 1'b0;
            alu_control    <= '0;
            pend_tag_reg   <= '0;
            settle_cnt_reg <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_tag        <= '0;
        end else begin
            if (pop) begin
                alu_a          <= head_entry[1:0];
                alu_b          <= head_entry[3:2];
                alu_cin        <= head_entry[4];
                alu_control    <= head_entry[7:5];
                pend_tag_reg   <= head_entry[ENTRY_W-1:8];
                settle_cnt_reg <= '0;
            end else if (state_reg == DRIVE && !capture) begin
                settle_cnt_reg <= settle_cnt_reg + 1'b1;
            end
            if (capture) begin
                rsp_data  <= alu_result;
                rsp_tag   <= pend_tag_reg;
                rsp_valid <= 1'b1;
            end else if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SELFCHECK_EN
    logic [3:0] golden;

    always_comb begin
        golden = 4'h0;
        case (alu_control)
            3'b000: golden = {2'b00, alu_a & alu_b};
            3'b001: golden = {2'b00, alu_a | alu_b};
            3'b010: golden = {2'b00, alu_a ^ alu_b};
            3'b011: golden = {2'b00, ~alu_a};
            3'b100: golden = {2'b00, alu_a} + {2'b00, alu_b} + {3'b000, alu_cin};
            3'b101: golden = {2'b00, alu_a} - {2'b00, alu_b} - {3'b000, alu_cin};
            3'b110: golden = {2'b00, alu_a} * {2'b00, alu_b};
            3'b111: golden = {3'b000, (alu_a > alu_b)};
            default: golden = 4'h0;
        endcase
    end

    // Sticky: once a bad ALU result is seen it stays flagged until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (capture && (alu_result != golden)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural 2-bit ALU attached to the alu_* outputs.
// Build with ALU_SELFCHECK_EN defined to also exercise the err flag.
module tb_alu_cmd_issuer;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [7:0]       cmd_data = 8'h00;
    logic [1:0]       alu_a, alu_b;
    logic             alu_cin;
    logic [2:0]       alu_control;
    logic [3:0]       alu_result;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [3:0]       rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
`ifdef ALU_SELFCHECK_EN
    logic             err;
`endif

    logic       alu_zero_fault = 1'b0;
    logic [3:0] alu_model;
    int         vec_cnt = 0;
    int         miss_cnt = 0;

    alu_cmd_issuer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_control(alu_control),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
`ifdef ALU_SELFCHECK_EN
        .err        (err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational ALU; the fault flag models a broken ALU.
    always_comb begin
        alu_model = 4'h0;
        case (alu_control)
            3'b000: alu_model = {2'b00, alu_a & alu_b};
            3'b001: alu_model = {2'b00, alu_a | alu_b};
            3'b010: alu_model = {2'b00, alu_a ^ alu_b};
            3'b011: alu_model = {2'b00, ~alu_a};
            3'b100: alu_model = {2'b00, alu_a} + {2'b00, alu_b} + {3'b000, alu_cin};
            3'b101: alu_model = {2'b00, alu_a} - {2'b00, alu_b} - {3'b000, alu_cin};
            3'b110: alu_model = {2'b00, alu_a} * {2'b00, alu_b};
            default: alu_model = {3'b000, (alu_a > alu_b)};
        endcase
    end
    assign alu_result = alu_zero_fault ? 4'h0 : alu_model;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge following the accepting posedge.
    task automatic push(input logic [7:0] d);
        bit done = 1'b0;
        cmd_data  = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            if (cmd_ready) done = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (!done) check_val("push_timeout", 32'd1, 32'd0);
    endtask

    task automatic get_rsp(input string tag, input logic [3:0] d, input logic [TAG_W-1:0] t);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (rsp_valid) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            check_val({tag, "_timeout"}, 32'd1, 32'd0);
        end else begin
            check_val({tag, "_data"}, 32'(rsp_data), 32'(d));
            check_val({tag, "_tag"}, 32'(rsp_tag), 32'(t));
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check_val({tag, "_drop"}, 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        int stray;

        // Reset state
        do_reset();
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_alu", 32'({alu_control, alu_cin, alu_b, alu_a}), 32'd0);
        check_val("rst_rsp", 32'({rsp_tag, rsp_data}), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
`ifdef ALU_SELFCHECK_EN
        check_val("rst_err", 32'(err), 32'd0);
`endif

        // T1: reset while a command is in DRIVE with more queued
        push(8'b100_1_11_11);
        push(8'b110_0_11_10);
        check_val("t1_pre_busy", 32'(busy), 32'd1);
        check_val("t1_pre_alu", 32'({alu_control, alu_cin, alu_b, alu_a}), 32'({3'b100, 1'b1, 2'b11, 2'b11}));
        push(8'b001_0_10_01);
        rst_n = 1'b0;
        #1;
        check_val("t1_alu", 32'({alu_control, alu_cin, alu_b, alu_a}), 32'd0);
        check_val("t1_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("t1_cmd_ready", 32'(cmd_ready), 32'd1);
        check_val("t1_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        stray     = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        rsp_ready = 1'b0;
        check_val("t1_no_stale_rsp", 32'(stray), 32'd0);

        // T2: add with latency check
        do_reset();
        rsp_ready = 1'b1;
        push(8'b100_1_11_11);
        check_val("t2_lat_n", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check_val("t2_lat_n1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check_val("t2_lat_n2", 32'(rsp_valid), 32'd1);
        check_val("t2_data", 32'(rsp_data), 32'h7);
        check_val("t2_tag", 32'(rsp_tag), 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_val("t2_done", 32'(rsp_valid), 32'd0);

        // T3: sub wrap, compare, not
        push(8'b101_0_01_00);
        get_rsp("t3_sub", 4'hF, 4'd1);
        push(8'b111_0_01_10);
        get_rsp("t3_gt", 4'h1, 4'd2);
        push(8'b011_0_00_01);
        get_rsp("t3_not", 4'h2, 4'd3);
        push(8'b101_1_11_01);
        get_rsp("t3_subc", 4'hD, 4'd4);

        // T4: backpressure fills FIFO plus one in flight
        do_reset();
        push(8'b000_0_11_01);
        push(8'b001_0_10_01);
        push(8'b010_0_11_01);
        push(8'b110_0_11_11);
        push(8'b111_0_11_00);
        cmd_data  = 8'b100_0_01_01;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_val("t4_full_ready", 32'(cmd_ready), 32'd0);
        check_val("t4_busy", 32'(busy), 32'd1);
        cmd_valid = 1'b0;
        get_rsp("t4_and", 4'h1, 4'd0);
        get_rsp("t4_or", 4'h3, 4'd1);
        check_val("t4_ready_back", 32'(cmd_ready), 32'd1);
        get_rsp("t4_xor", 4'h2, 4'd2);
        get_rsp("t4_mul", 4'h9, 4'd3);
        get_rsp("t4_gt0", 4'h0, 4'd4);
        repeat (4) @(negedge clk);
        check_val("t4_idle_busy", 32'(busy), 32'd0);
        check_val("t4_no_extra", 32'(rsp_valid), 32'd0);

        // T5: 18 adds, tag wrap
        do_reset();
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    push({3'b100, 1'(i % 2), 2'((i / 4) % 4), 2'(i % 4)});
                end
            end
            begin
                for (int i = 0; i < 18; i++) begin
                    get_rsp($sformatf("t5_add%0d", i),
                            4'((i % 4) + ((i / 4) % 4) + (i % 2)), 4'(i % 16));
                end
            end
        join
        check_val("t5_drained", 32'(busy), 32'd0);

`ifdef ALU_SELFCHECK_EN
        // T6: broken ALU result sets sticky err
        do_reset();
        alu_zero_fault = 1'b1;
        push(8'b110_0_11_10);
        get_rsp("t6_bad", 4'h0, 4'd0);
        alu_zero_fault = 1'b0;
        check_val("t6_err_set", 32'(err), 32'd1);
        push(8'b100_0_01_01);
        get_rsp("t6_good", 4'h2, 4'd1);
        check_val("t6_err_sticky", 32'(err), 32'd1);
        do_reset();
        check_val("t6_err_clr", 32'(err), 32'd0);
        push(8'b110_0_11_10);
        get_rsp("t6_ok", 4'h6, 4'd0);
        check_val("t6_err_ok", 32'(err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
